// File: rtl/gate_pipe.sv
// gate_pipe: bitwise two-operand gate feeding a DEPTH-entry result FIFO with valid/ready on both sides.
// Optional accept/zero-result statistics are compiled in with GATE_PIPE_STATS_EN.
module gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [2:0]               op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         z,
  output logic [$clog2(DEPTH):0]   level
`ifdef GATE_PIPE_STATS_EN
  ,
  output logic [15:0]              acc_count,
  output logic [15:0]              zero_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] result;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (sel)
      3'd0:    gate_fn = x & ~y;
      3'd1:    gate_fn = x & y;
      3'd2:    gate_fn = x | y;
      3'd3:    gate_fn = x ^ y;
      3'd4:    gate_fn = ~(x & y);
      3'd5:    gate_fn = ~(x | y);
      3'd6:    gate_fn = ~(x ^ y);
      default: gate_fn = ~x;
    endcase
  endfunction

  // Handshake qualifiers come from registered level only, so a pop never frees a slot in the same cycle.
  assign in_ready  = (level != FULL);
  assign out_valid = (level != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign result    = gate_fn(op, a, b);
  assign z         = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef GATE_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_count  <= '0;
      zero_count <= '0;
    end else if (accept) begin
      if (acc_count != 16'hFFFF) begin
        acc_count <= acc_count + 16'd1;
      end
      if ((result == '0) && (zero_count != 16'hFFFF)) begin
        zero_count <= zero_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/gate_pipe.md
GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1-64).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the result FIFO entry count (power of two, 2-16).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  the operand set is presented.
REQ-006 The block SHALL have port in_ready  output  1  the block can accept an operand set this cycle.
REQ-007 The block SHALL have ports a and b  input  WIDTH each  the operands.
REQ-008 The block SHALL have port op  input  3  the gate select, sampled with a and b.
REQ-009 The block SHALL have port out_valid  output  1  the head result is valid.
REQ-010 The block SHALL have port out_ready  input  1  the consumer takes the head result.
REQ-011 The block SHALL have port z  output  WIDTH  the head result.
REQ-012 The block SHALL have port level  output  log2(DEPTH)+1  the current FIFO occupancy.

Function
REQ-013 The op encoding SHALL be bitwise: 0 a&~b (AND-NOT), 1 a&b, 2 a|b, 3 a^b, 4 ~(a&b), 5 ~(a|b), 6 ~(a^b), 7 ~a (b ignored).
REQ-014 An accept SHALL occur when in_valid && in_ready at a rising edge; the result of (a,b,op) at that edge SHALL be written to the FIFO tail.
REQ-015 Latency SHALL be 1 cycle: a result accepted into an empty FIFO SHALL appear on z with out_valid=1 in the cycle after the accept edge.
REQ-016 A pop SHALL occur when out_valid && out_ready at a rising edge; z SHALL then advance to the next entry, or out_valid SHALL drop if none remains.
REQ-017 Ordering SHALL be strict FIFO; no result is dropped, duplicated or reordered.
REQ-018 in_ready SHALL equal (level != DEPTH), combinational from registered state only; it SHALL NOT depend on out_ready.
REQ-019 When full, a pop SHALL NOT enable an accept in the same cycle; the accept occurs in the following cycle.
REQ-020 Simultaneous accept and pop when 0 < level < DEPTH SHALL leave level unchanged.
REQ-021 Pointers SHALL wrap modulo DEPTH; level SHALL be exact at 0 and DEPTH.
REQ-022 out_valid SHALL equal (level != 0); z SHALL be held stable while out_valid && !out_ready.
REQ-023 in_valid low SHALL cause no state change; operand values are don't-care then.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL set level=0, out_valid=0, in_ready=1, z=0, pointers=0, and stats counters=0.
REQ-025 Reset mid-operation SHALL discard all stored results; accepts and pops presented during reset cycles SHALL be ignored.
REQ-026 The first accept SHALL be possible in the first cycle with rst=0.

Configuration
REQ-027 With macro GATE_PIPE_STATS_EN defined, the block SHALL add outputs acc_count (16 bits) and zero_count (16 bits).
REQ-028 acc_count SHALL increment on every accept; zero_count SHALL increment on every accept whose result is all zeros.
REQ-029 Both stats counters SHALL saturate at 16'hFFFF.
REQ-030 Without GATE_PIPE_STATS_EN, the stats ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover, with WIDTH=8: op=0, a=8'hF0, b=8'h3C, out_ready=1 -> z=8'hC0, out_valid=1 one cycle after accept.
REQ-032 The bench SHALL cover the 1-bit truth table of AND-NOT, with WIDTH=1 and op=0: (a,b)=(0,0),(1,0),(1,1),(0,1) -> z=0,1,0,0 in order.
REQ-033 The bench SHALL cover fill and overflow: out_ready=0 with 5 accepts attempted at DEPTH=4 -> in_ready=0 after the 4th, level=4, the 5th is not accepted; draining yields the 4 results in order.
REQ-034 The bench SHALL cover full plus pop: with level=4, out_ready=1 and in_valid=1 -> pop only that cycle (level=3), then accept on the next cycle (level back to 4).
REQ-035 The bench SHALL cover reset mid-stream: level=3, then rst for 1 cycle -> level=0, out_valid=0, in_ready=1, and no stale results appear afterwards.
REQ-036 The bench SHALL cover stats with GATE_PIPE_STATS_EN defined: 3 accepts with op=1, a=8'h0F, b=8'hF0 plus 2 accepts with op=2 -> acc_count=5, zero_count=3.
